sqrt_iter: RTL

Parametrised iterative integer square-root unit, the successor to the fixed 8-bit odd-subtraction root finder. It computes floor(sqrt(in)) and the remainder for a WIDTH-bit unsigned operand using restoring digit recurrence, producing one root bit per cycle. It sits beside the existing switch-driven datapath and is driven by the same go/over level handshake.

---
 rtl/sqrt_pkg.sv | 23 ++
 rtl/sqrt_step.sv | 39 +++
 rtl/sqrt_iter.sv | 129 ++++++++++++
 3 files changed

// File: rtl/sqrt_pkg.sv
// Shared definitions for the iterative square-root unit: FSM encoding and
// elaboration-time width helpers.
package sqrt_pkg;

   // Controller states; IDLE is the reset state.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Operand width must be even (two radicand bits consumed per root bit)
   // and at least one digit pair wide.
   function automatic bit width_ok(input int w);
      return (w >= 2) && ((w % 2) == 0);
   endfunction

   // Root width for a given operand width.
   function automatic int root_width(input int w);
      return w / 2;
   endfunction

endpackage : sqrt_pkg

// File: rtl/sqrt_step.sv
// One restoring digit-recurrence step: brings down one radicand digit pair,
// trial-subtracts (4q+1) and decides the next root bit.
module sqrt_step #(
   parameter int RW = 4
) (
   input  logic [RW+1:0] r_i,
   input  logic [RW-1:0] q_i,
   input  logic [1:0]    pair_i,
   output logic [RW+1:0] r_o,
   output logic [RW-1:0] q_o
);
   import sqrt_pkg::*;

   logic [RW+1:0] r_shift_s;
   logic [RW+1:0] trial_s;
   logic [RW+2:0] diff_s;
   logic          fit_s;

   // Shift the partial remainder and append the next digit pair; the
   // subtraction carries one extra bit so the borrow is unambiguous even
   // when the shifted remainder uses its top bit.
   always_comb begin
      r_shift_s = (r_i << 2) | (RW+2)'(pair_i);
      trial_s   = (RW+2)'({q_i, 2'b01});
      diff_s    = {1'b0, r_shift_s} - {1'b0, trial_s};
      fit_s     = ~diff_s[RW+2];
   end

   // Keep the difference when the trial fits, otherwise restore.
   always_comb begin
      if (fit_s) begin
         r_o = diff_s[RW+1:0];
      end else begin
         r_o = r_shift_s;
      end
      q_o = (q_i << 1) | RW'(fit_s);
   end

endmodule : sqrt_step

// File: rtl/sqrt_iter.sv
// Iterative integer square root: floor(sqrt(in)) and remainder, one root
// bit per clock, driven by a go/over level handshake.
module sqrt_iter
   import sqrt_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       go,
   input  logic [WIDTH-1:0]           in,
   output logic                       busy,
   output logic                       over,
   output logic [root_width(WIDTH)-1:0] out,
   output logic [root_width(WIDTH):0]   rem
);

   localparam int RW    = root_width(WIDTH);
   localparam int CNT_W = (RW > 1) ? $clog2(RW) : 1;

   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("sqrt_iter: WIDTH must be even and >= 2");
   end

   state_e          state_q, state_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [RW+1:0]   r_q, r_d;
   logic [RW-1:0]   root_q, root_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            busy_q, busy_d;
   logic            over_q, over_d;
   logic [RW-1:0]   out_q, out_d;
   logic [RW:0]     rem_q, rem_d;

   logic [RW+1:0]   step_r_s;
   logic [RW-1:0]   step_q_s;
   logic            last_s;

   sqrt_step #(.RW(RW)) u_step (
      .r_i    (r_q),
      .q_i    (root_q),
      .pair_i (x_q[WIDTH-1 -: 2]),
      .r_o    (step_r_s),
      .q_o    (step_q_s)
   );

   assign last_s = (cnt_q == CNT_W'(RW - 1));

   // Next-state and datapath control; everything holds unless a state acts.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      r_d     = r_q;
      root_d  = root_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      rem_d   = rem_q;
      case (state_q)
         ST_IDLE: begin
            if (go) begin
               x_d     = in;
               r_d     = '0;
               root_d  = '0;
               cnt_d   = '0;
               state_d = ST_CALC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CALC: begin
            x_d    = x_q << 2;
            r_d    = step_r_s;
            root_d = step_q_s;
            cnt_d  = cnt_q + 1'b1;
            if (last_s) begin
               out_d   = step_q_s;
               rem_d   = step_r_s[RW:0];
               state_d = ST_DONE;
            end else begin
               state_d = ST_CALC;
            end
         end
         ST_DONE: begin
            // Only a low go releases DONE, so a held go cannot retrigger.
            if (!go) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_CALC);
      over_d = (state_d == ST_DONE);
   end

   // State, datapath and registered handshake/result outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         r_q     <= '0;
         root_q  <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         over_q  <= 1'b0;
         out_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         r_q     <= r_d;
         root_q  <= root_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         over_q  <= over_d;
         out_q   <= out_d;
         rem_q   <= rem_d;
      end
   end

   assign busy = busy_q;
   assign over = over_q;
   assign out  = out_q;
   assign rem  = rem_q;

endmodule : sqrt_iter
